exe_stage_unit: RTL and testbench
=================================

// Module: exe_stage_unit
// PURPOSE
//  Execute-stage consumer of the ID/EX pipeline register. Decodes exe_cmd, generates Val2
//  (rotated immediate / shifted Rm / load-store offset), runs the ALU, owns the NZCV status
//  register, resolves branches (target + flush request) and registers results into EX/MEM.
//  Sits between the ID/EX register and the MEM stage; the status output feeds ID condition check.
// PARAMETERS
//  SR_INIT     4'h0  NZCV value loaded on reset
//  WORD_SHIFT  2     left shift applied to signed_imm_24 for branch offset
// PORTS
//  clk            in   1   clock
//  rst            in   1   synchronous, active-high reset
//  freeze         in   1   hold EX/MEM regs and SR (memory stall)
//  wb_en_in       in   1   write-back enable from ID/EX
//  mem_r_en_in    in   1   load
//  mem_w_en_in    in   1   store
//  B_in           in   1   branch
//  S_in           in   1   update status
//  PC_in          in   32  PC+4 of instruction
//  exe_cmd_in     in   4   ALU command
//  val_rn_in      in   32  Rn operand
//  val_rm_in      in   32  Rm operand / store data
//  imm_in         in   1   shifter operand is immediate
//  shift_operand_in in 12  shifter operand field
//  signed_imm_24_in in 24  branch offset (words)
//  dest_in        in   4   destination register
//  status         out  4   current NZCV {N,Z,C,V}
//  branch_taken   out  1   combinational: B_in & ~freeze; flushes IF/ID and ID/EX
//  branch_addr    out  32  PC_in + (sext(signed_imm_24_in) << WORD_SHIFT)
//  alu_result     out  32  registered ALU result / memory address
//  st_val         out  32  registered val_rm_in
//  dest           out  4   registered dest_in
//  wb_en, mem_r_en, mem_w_en  out 1 each  registered controls
// BEHAVIOUR
//  - Reset (rst at posedge, overrides freeze): alu_result/st_val=0, dest=0, wb_en/mem_r_en/
//    mem_w_en=0, status=SR_INIT.
//  - Latency 1: EX/MEM outputs load inputs at posedge when ~rst & ~freeze; freeze holds all.
//  - Val2: imm_in=1 -> {24'b0,op[7:0]} rotated right by 2*op[11:8].
//    else mem_r_en_in|mem_w_en_in -> zero-extended op[11:0].
//    else val_rm_in shifted by op[11:7] type op[6:5]: 00 LSL,01 LSR,10 ASR,11 ROR; amount 0 = pass.
//  - exe_cmd: 0001 MOV=Val2; 1001 MVN=~Val2; 0010 ADD=Rn+Val2; 0011 ADC=Rn+Val2+C;
//    0100 SUB/CMP=Rn-Val2; 0101 SBC=Rn-Val2-~C; 0110 AND/TST; 0111 ORR; 1000 EOR; others -> 0, no flags.
//  - Arithmetic in 33 bits; C=bit32 (SUB/SBC: C=1 means no borrow); V=signed overflow.
//    N=result[31], Z=(result==0). Logical ops and MOV/MVN: N,Z updated, C,V unchanged.
//  - SR loads new flags at posedge iff S_in & ~freeze & ~rst; otherwise holds. ADC/SBC use
//    pre-update C. CMP/TST arrive with wb_en_in=0; block does not gate wb_en itself.
//  - Branch: branch_taken/branch_addr combinational same cycle; addr wraps mod 2^32.
//    B_in with S_in=0 never touches SR. Flush of following stages is the consumer's job.
//  - Back-to-back S instructions: second sees SR written by first (no bypass needed, 1 cycle apart).
//  - Reset mid-stall: rst wins, next cycle free-running.
// TESTING
//  1. rst=1 one cycle -> status=SR_INIT, all registered outputs 0, branch_taken follows B_in&~freeze.
//  2. ADD S=1 Rn=7FFFFFFF Val2 imm 0x01 -> alu_result=80000000, status N=1 Z=0 C=0 V=1.
//  3. SUB S=1 Rn=5 Rm=5 (LSL 0) -> result 0, NZCV=0110; then ADC Rn=1 imm 0 -> result 2.
//  4. imm_in=1 op=0x4FF -> Val2=FF000000; op shift ASR 4 on Rm=80000000 -> F8000000.
//  5. B_in=1 PC_in=0x100 imm24=FFFFFE -> branch_taken=1, branch_addr=0x0F8; SR unchanged.
//  6. freeze=1 for 3 cycles with ADD S=1 -> outputs and status hold; released -> update next edge.

Source files
------------

// File: rtl/exe_stage_unit.sv
// Execute stage: Val2 generation, ALU, NZCV status register, branch resolution,
// and the EX/MEM pipeline register feeding the memory stage.
module exe_stage_unit #(
  parameter logic [3:0] SR_INIT    = 4'h0,
  parameter int         WORD_SHIFT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        wb_en_in,
  input  logic        mem_r_en_in,
  input  logic        mem_w_en_in,
  input  logic        B_in,
  input  logic        S_in,
  input  logic [31:0] PC_in,
  input  logic [3:0]  exe_cmd_in,
  input  logic [31:0] val_rn_in,
  input  logic [31:0] val_rm_in,
  input  logic        imm_in,
  input  logic [11:0] shift_operand_in,
  input  logic [23:0] signed_imm_24_in,
  input  logic [3:0]  dest_in,
  output logic [3:0]  status,
  output logic        branch_taken,
  output logic [31:0] branch_addr,
  output logic [31:0] alu_result,
  output logic [31:0] st_val,
  output logic [3:0]  dest,
  output logic        wb_en,
  output logic        mem_r_en,
  output logic        mem_w_en
);

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  // ------------------------------------------------------------------
  // Val2 generation
  // ------------------------------------------------------------------
  logic [31:0] imm_ext;
  logic [4:0]  rot_amt;
  logic [63:0] rot_dbl;
  logic [31:0] rot_val;
  logic [4:0]  sh_amt;
  logic [63:0] ror_dbl;
  logic [31:0] shift_val;
  logic [31:0] val2;

  always_comb begin
    imm_ext = {24'b0, shift_operand_in[7:0]};
    rot_amt = {shift_operand_in[11:8], 1'b0};
    rot_dbl = {imm_ext, imm_ext} >> rot_amt;
    rot_val = rot_dbl[31:0];

    sh_amt  = shift_operand_in[11:7];
    ror_dbl = {val_rm_in, val_rm_in} >> sh_amt;
    case (shift_operand_in[6:5])
      SH_LSL:  shift_val = val_rm_in << sh_amt;
      SH_LSR:  shift_val = val_rm_in >> sh_amt;
      SH_ASR:  shift_val = $signed(val_rm_in) >>> sh_amt;
      SH_ROR:  shift_val = ror_dbl[31:0];
      default: shift_val = val_rm_in;
    endcase

    // Memory instructions use the raw 12-bit field as an unsigned offset.
    if (imm_in)
      val2 = rot_val;
    else if (mem_r_en_in || mem_w_en_in)
      val2 = {20'b0, shift_operand_in};
    else
      val2 = shift_val;
  end

  // ------------------------------------------------------------------
  // ALU and next flags
  // ------------------------------------------------------------------
  logic [32:0] sum;
  logic [31:0] alu_out;
  logic        c_next;
  logic        v_next;
  logic        cmd_valid;
  logic [3:0]  flags_next;

  always_comb begin
    sum       = '0;
    alu_out   = '0;
    c_next    = status[1];
    v_next    = status[0];
    cmd_valid = 1'b1;
    case (exe_cmd_in)
      CMD_MOV: alu_out = val2;
      CMD_MVN: alu_out = ~val2;
      CMD_ADD: begin
        sum     = {1'b0, val_rn_in} + {1'b0, val2};
        alu_out = sum[31:0];
        c_next  = sum[32];
        v_next  = (val_rn_in[31] == val2[31]) && (sum[31] != val_rn_in[31]);
      end
      CMD_ADC: begin
        sum     = {1'b0, val_rn_in} + {1'b0, val2} + {32'b0, status[1]};
        alu_out = sum[31:0];
        c_next  = sum[32];
        v_next  = (val_rn_in[31] == val2[31]) && (sum[31] != val_rn_in[31]);
      end
      // Subtraction as Rn + ~Val2 + carry-in, so carry out means no borrow.
      CMD_SUB: begin
        sum     = {1'b0, val_rn_in} + {1'b0, ~val2} + 33'd1;
        alu_out = sum[31:0];
        c_next  = sum[32];
        v_next  = (val_rn_in[31] != val2[31]) && (sum[31] != val_rn_in[31]);
      end
      CMD_SBC: begin
        sum     = {1'b0, val_rn_in} + {1'b0, ~val2} + {32'b0, status[1]};
        alu_out = sum[31:0];
        c_next  = sum[32];
        v_next  = (val_rn_in[31] != val2[31]) && (sum[31] != val_rn_in[31]);
      end
      CMD_AND: alu_out = val_rn_in & val2;
      CMD_ORR: alu_out = val_rn_in | val2;
      CMD_EOR: alu_out = val_rn_in ^ val2;
      default: cmd_valid = 1'b0;
    endcase

    if (cmd_valid)
      flags_next = {alu_out[31], (alu_out == 32'b0), c_next, v_next};
    else
      flags_next = status;
  end

  // ------------------------------------------------------------------
  // Branch resolution
  // ------------------------------------------------------------------
  logic [31:0] imm_sext;

  always_comb begin
    imm_sext     = {{8{signed_imm_24_in[23]}}, signed_imm_24_in};
    branch_addr  = PC_in + (imm_sext << WORD_SHIFT);
    branch_taken = B_in & ~freeze;
  end

  // ------------------------------------------------------------------
  // Status register and EX/MEM register; reset overrides freeze
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      status     <= SR_INIT;
      alu_result <= '0;
      st_val     <= '0;
      dest       <= '0;
      wb_en      <= 1'b0;
      mem_r_en   <= 1'b0;
      mem_w_en   <= 1'b0;
    end else if (!freeze) begin
      if (S_in)
        status <= flags_next;
      alu_result <= alu_out;
      st_val     <= val_rm_in;
      dest       <= dest_in;
      wb_en      <= wb_en_in;
      mem_r_en   <= mem_r_en_in;
      mem_w_en   <= mem_w_en_in;
    end
  end

endmodule

// File: tb/tb_exe_stage_unit.sv
// Directed bench for exe_stage_unit: a behavioural model feeds an expected queue
// that is checked every cycle, plus hand-computed literal checks per scenario.
module tb_exe_stage_unit;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        wb_en_in;
  logic        mem_r_en_in;
  logic        mem_w_en_in;
  logic        B_in;
  logic        S_in;
  logic [31:0] PC_in;
  logic [3:0]  exe_cmd_in;
  logic [31:0] val_rn_in;
  logic [31:0] val_rm_in;
  logic        imm_in;
  logic [11:0] shift_operand_in;
  logic [23:0] signed_imm_24_in;
  logic [3:0]  dest_in;
  logic [3:0]  status;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [31:0] alu_result;
  logic [31:0] st_val;
  logic [3:0]  dest;
  logic        wb_en;
  logic        mem_r_en;
  logic        mem_w_en;

  exe_stage_unit dut (
    .clk(clk), .rst(rst), .freeze(freeze),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .B_in(B_in), .S_in(S_in), .PC_in(PC_in), .exe_cmd_in(exe_cmd_in),
    .val_rn_in(val_rn_in), .val_rm_in(val_rm_in), .imm_in(imm_in),
    .shift_operand_in(shift_operand_in), .signed_imm_24_in(signed_imm_24_in),
    .dest_in(dest_in), .status(status), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .alu_result(alu_result), .st_val(st_val),
    .dest(dest), .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en)
  );

  localparam logic [3:0] MOV = 4'b0001, MVN = 4'b1001, ADD = 4'b0010, ADC = 4'b0011;
  localparam logic [3:0] SUB = 4'b0100, SBC = 4'b0101, AND_ = 4'b0110, ORR = 4'b0111;
  localparam logic [3:0] EOR = 4'b1000, BAD = 4'b1111;

  int n_cmp  = 0;
  int n_fail = 0;

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------
  // Behavioural model
  // ------------------------------------------------------------------
  function automatic logic [31:0] m_val2(input logic imm, input logic mem,
                                         input logic [31:0] rm, input logic [11:0] op);
    logic [31:0] x;
    int amt;
    if (imm) begin
      x = {24'b0, op[7:0]};
      amt = 2 * int'(op[11:8]);
      for (int k = 0; k < amt; k++) x = {x[0], x[31:1]};
    end else if (mem) begin
      x = {20'b0, op};
    end else begin
      x = rm;
      amt = int'(op[11:7]);
      for (int k = 0; k < amt; k++) begin
        case (op[6:5])
          2'b00:   x = {x[30:0], 1'b0};
          2'b01:   x = {1'b0, x[31:1]};
          2'b10:   x = {x[31], x[31:1]};
          default: x = {x[0], x[31:1]};
        endcase
      end
    end
    return x;
  endfunction

  logic [3:0]  m_status;
  logic [31:0] m_alu, m_st;
  logic [3:0]  m_dest;
  logic        m_wb, m_mr, m_mw;
  logic [74:0] exp_q[$];

  always @(posedge clk) begin : model
    logic [31:0] v2, res;
    longint a, b, sa, sb, t, st, bor;
    logic c, v, valid;
    if (rst) begin
      m_status = 4'h0; m_alu = '0; m_st = '0; m_dest = '0;
      m_wb = 1'b0; m_mr = 1'b0; m_mw = 1'b0;
    end else if (!freeze) begin
      v2  = m_val2(imm_in, mem_r_en_in | mem_w_en_in, val_rm_in, shift_operand_in);
      a   = {32'b0, val_rn_in};
      b   = {32'b0, v2};
      sa  = longint'($signed(val_rn_in));
      sb  = longint'($signed(v2));
      c   = m_status[1];
      v   = m_status[0];
      bor = c ? 64'd0 : 64'd1;
      valid = 1'b1;
      res = '0;
      t   = 0;
      st  = 0;
      case (exe_cmd_in)
        MOV:  res = v2;
        MVN:  res = ~v2;
        AND_: res = val_rn_in & v2;
        ORR:  res = val_rn_in | v2;
        EOR:  res = val_rn_in ^ v2;
        ADD, ADC: begin
          t  = a + b + ((exe_cmd_in == ADC && c) ? 64'd1 : 64'd0);
          st = sa + sb + ((exe_cmd_in == ADC && c) ? 64'd1 : 64'd0);
          res = t[31:0];
          c = (t >= 64'h1_0000_0000);
          v = (st > 64'sd2147483647) || (st < -64'sd2147483648);
        end
        SUB, SBC: begin
          if (exe_cmd_in == SUB) bor = 0;
          t  = a - b - bor;
          st = sa - sb - bor;
          res = t[31:0];
          c = (a >= b + bor);
          v = (st > 64'sd2147483647) || (st < -64'sd2147483648);
        end
        default: valid = 1'b0;
      endcase
      if (S_in && valid) m_status = {res[31], res == 32'b0, c, v};
      m_alu = res; m_st = val_rm_in; m_dest = dest_in;
      m_wb = wb_en_in; m_mr = mem_r_en_in; m_mw = mem_w_en_in;
    end
    exp_q.push_back({m_status, m_alu, m_st, m_dest, m_wb, m_mr, m_mw});
  end

  // compare process: registered outputs from the queue, branch outputs from inputs
  always @(negedge clk) begin : compare
    logic [74:0] e;
    longint o, ta;
    logic [31:0] eb;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("status",     32'(status),     32'(e[74:71]));
      check("alu_result", alu_result,      e[70:39]);
      check("st_val",     st_val,          e[38:7]);
      check("dest",       32'(dest),       32'(e[6:3]));
      check("wb_en",      32'(wb_en),      32'(e[2]));
      check("mem_r_en",   32'(mem_r_en),   32'(e[1]));
      check("mem_w_en",   32'(mem_w_en),   32'(e[0]));
    end
    o = {40'b0, signed_imm_24_in};
    if (o >= 64'sh80_0000) o = o - 64'sh100_0000;
    ta = {32'b0, PC_in} + o * 4;
    eb = ta[31:0];
    check("branch_taken", 32'(branch_taken), 32'(B_in & ~freeze));
    check("branch_addr",  branch_addr, eb);
  end

  // ------------------------------------------------------------------
  // Driver tasks
  // ------------------------------------------------------------------
  task automatic drive(input logic [3:0] cmd, input logic s, input logic [31:0] rn,
                       input logic [31:0] rm, input logic imm, input logic [11:0] op,
                       input logic mr, input logic mw, input logic wb, input logic [3:0] dst);
    @(negedge clk); #1;
    rst = 1'b0; freeze = 1'b0; B_in = 1'b0;
    exe_cmd_in = cmd; S_in = s; val_rn_in = rn; val_rm_in = rm; imm_in = imm;
    shift_operand_in = op; mem_r_en_in = mr; mem_w_en_in = mw; wb_en_in = wb; dest_in = dst;
  endtask

  task automatic drive_branch(input logic [31:0] pc, input logic [23:0] off, input logic frz);
    @(negedge clk); #1;
    rst = 1'b0; freeze = frz; B_in = 1'b1; S_in = 1'b0; exe_cmd_in = 4'b0000;
    PC_in = pc; signed_imm_24_in = off; wb_en_in = 1'b0;
    mem_r_en_in = 1'b0; mem_w_en_in = 1'b0; imm_in = 1'b0; shift_operand_in = '0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // ------------------------------------------------------------------
  // Directed stimulus
  // ------------------------------------------------------------------
  initial begin
    rst = 1'b1; freeze = 1'b0; wb_en_in = 1'b0; mem_r_en_in = 1'b0; mem_w_en_in = 1'b0;
    B_in = 1'b1; S_in = 1'b0; PC_in = 32'h100; exe_cmd_in = '0; val_rn_in = '0;
    val_rm_in = '0; imm_in = 1'b0; shift_operand_in = '0; signed_imm_24_in = 24'h1;
    dest_in = '0;

    // reset
    tick();
    check("rst_status", 32'(status), 32'h0);
    check("rst_alu", alu_result, 32'h0);
    check("rst_wb", 32'(wb_en), 32'h0);
    check("rst_branch_taken", 32'(branch_taken), 32'h1);
    check("rst_branch_addr", branch_addr, 32'h104);
    @(negedge clk); #1; freeze = 1'b1;
    #1 check("rst_frz_branch_taken", 32'(branch_taken), 32'h0);
    tick();

    // ADD overflow
    drive(ADD, 1, 32'h7FFFFFFF, 32'h0, 1, 12'h001, 0, 0, 1, 4'd3); tick();
    check("add_result", alu_result, 32'h80000000);
    check("add_nzcv", 32'(status), 32'h9);
    check("add_dest", 32'(dest), 32'h3);

    // SUB to zero, then ADC using the carry it produced
    drive(SUB, 1, 32'h5, 32'h5, 0, 12'h000, 0, 0, 1, 4'd1); tick();
    check("sub_result", alu_result, 32'h0);
    check("sub_nzcv", 32'(status), 32'h6);
    drive(ADC, 1, 32'h1, 32'h0, 1, 12'h000, 0, 0, 1, 4'd2); tick();
    check("adc_result", alu_result, 32'h2);
    check("adc_nzcv", 32'(status), 32'h0);

    // Val2 forms
    drive(MOV, 1, 32'h0, 32'h0, 1, 12'h4FF, 0, 0, 1, 4'd4); tick();
    check("mov_rot_imm", alu_result, 32'hFF000000);
    check("mov_nzcv", 32'(status), 32'h8);
    drive(MOV, 0, 32'h0, 32'h80000000, 0, 12'h240, 0, 0, 1, 4'd4); tick();
    check("mov_asr4", alu_result, 32'hF8000000);
    drive(ADD, 0, 32'h1, 32'h0000000F, 0, 12'h200, 0, 0, 1, 4'd6); tick();
    check("add_lsl4", alu_result, 32'h000000F1);
    drive(MOV, 0, 32'h0, 32'hF0000000, 0, 12'h420, 0, 0, 1, 4'd6); tick();
    check("mov_lsr8", alu_result, 32'h00F00000);
    drive(EOR, 0, 32'hFFFFFFFF, 32'h12345678, 0, 12'h260, 0, 0, 1, 4'd7); tick();
    check("eor_ror4", alu_result, 32'h7EDCBA98);
    drive(MVN, 0, 32'h0, 32'h0, 1, 12'h000, 0, 0, 1, 4'd7);
    drive(AND_, 0, 32'hF0F0F0F0, 32'h0, 1, 12'h0FF, 0, 0, 1, 4'd8);
    drive(ORR, 0, 32'h00000100, 32'h0, 1, 12'h0FF, 0, 0, 1, 4'd8);

    // load / store offsets override the shifter
    drive(ADD, 0, 32'h1000, 32'hDEADBEEF, 0, 12'hFFC, 1, 0, 1, 4'd5); tick();
    check("ldr_addr", alu_result, 32'h00001FFC);
    check("ldr_mem_r", 32'(mem_r_en), 32'h1);
    drive(ADD, 0, 32'h2000, 32'hCAFEF00D, 0, 12'h840, 0, 1, 0, 4'd9); tick();
    check("str_addr", alu_result, 32'h00002840);
    check("str_val", st_val, 32'hCAFEF00D);

    // borrow chain, undefined command, CMP, signed subtract overflow
    drive(SUB, 1, 32'h0, 32'h0, 1, 12'h001, 0, 0, 1, 4'd1); tick();
    check("sub_borrow_nzcv", 32'(status), 32'h8);
    drive(SBC, 1, 32'd10, 32'h0, 1, 12'h003, 0, 0, 1, 4'd1); tick();
    check("sbc_result", alu_result, 32'h6);
    check("sbc_nzcv", 32'(status), 32'h2);
    drive(BAD, 1, 32'h5, 32'h5, 0, 12'h000, 0, 0, 1, 4'd1); tick();
    check("bad_result", alu_result, 32'h0);
    check("bad_nzcv", 32'(status), 32'h2);
    drive(SUB, 1, 32'h3, 32'h0, 1, 12'h005, 0, 0, 0, 4'd0); tick();
    check("cmp_nzcv", 32'(status), 32'h8);
    drive(SUB, 1, 32'h80000000, 32'h0, 1, 12'h001, 0, 0, 1, 4'd2); tick();
    check("sub_ovf_nzcv", 32'(status), 32'h3);

    // branches
    drive_branch(32'h100, 24'hFFFFFE, 0);
    #1 check("br_taken", 32'(branch_taken), 32'h1);
    check("br_addr", branch_addr, 32'h000000F8);
    tick();
    check("br_sr_hold", 32'(status), 32'h3);
    drive_branch(32'h4, 24'h800000, 0);
    #1 check("br_addr_min", branch_addr, 32'hFE000004);
    drive_branch(32'hFFFFFFFC, 24'h000001, 0);
    #1 check("br_addr_wrap", branch_addr, 32'h0);
    drive_branch(32'h200, 24'h000010, 1);
    #1 check("br_frozen", 32'(branch_taken), 32'h0);

    // freeze holds for three cycles, then the held instruction lands
    drive(MOV, 0, 32'h0, 32'h0, 1, 12'h055, 0, 0, 1, 4'd10); tick();
    check("pre_frz", alu_result, 32'h55);
    drive(ADD, 1, 32'h1, 32'h0, 1, 12'h001, 0, 0, 1, 4'd11);
    freeze = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("frz_alu", alu_result, 32'h55);
      check("frz_status", 32'(status), 32'h3);
      check("frz_dest", 32'(dest), 32'hA);
    end
    @(negedge clk); #1; freeze = 1'b0;
    tick();
    check("unfrz_alu", alu_result, 32'h2);
    check("unfrz_status", 32'(status), 32'h0);

    // reset during a stall wins, then runs freely
    drive(SUB, 1, 32'h0, 32'h0, 1, 12'h001, 0, 0, 1, 4'd3); tick();
    @(negedge clk); #1; freeze = 1'b1; rst = 1'b1;
    tick();
    check("rst_stall_alu", alu_result, 32'h0);
    check("rst_stall_status", 32'(status), 32'h0);
    drive(MOV, 0, 32'h0, 32'h0, 1, 12'h007, 0, 0, 1, 4'd1); tick();
    check("post_rst_alu", alu_result, 32'h7);

    drive(4'b0000, 0, 32'h0, 32'h0, 0, 12'h000, 0, 0, 0, 4'd0);
    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
